fetch_task_fsm: RTL and testbench
=================================

// Module: fetch_task_fsm
// PURPOSE
//  Single-slot fetch-task controller. Accepts a task allocation on the io_alloc handshake.
//  Issues one fetch instruction per beat on io_fthInst, then tracks outstanding fetch
//  responses. Reports completion on io_done.
//  Its state register and handshakes are exported for the state-transfer assertion checker.
//  The checker requires that an alloc handshake in FREE is followed one cycle later by
//  io_fthInst_valid.
// PARAMETERS
//  ADDR_W      32  fetch address width
//  LEN_W       4   beat-count field width; a task is io_alloc_len+1 beats (1..2^LEN_W)
//  BEAT_BYTES  8   address increment per beat (power of 2)
//  MAX_OUT     4   max outstanding fetches (>=1)
// PORTS
//  clock            in   1       single clock, rising edge
//  reset            in   1       asynchronous, active-high
//  io_alloc_valid   in   1       task allocation request
//  io_alloc_ready   out  1       slot free, alloc accepted
//  io_alloc_addr    in   ADDR_W  task base address
//  io_alloc_len     in   LEN_W   beats minus one
//  io_fthInst_valid out  1       fetch instruction valid
//  io_fthInst_ready in   1       downstream accepts fetch
//  io_fthInst_addr  out  ADDR_W  fetch address of current beat
//  io_fthResp_valid in   1       one fetch response returned (always accepted)
//  io_flush         in   1       abort current task
//  io_done_valid    out  1       task complete
//  io_done_ready    in   1       completion consumed
//  io_err           out  1       sticky: response received with zero outstanding
//  stateReg_value   out  3       current state encoding (for assertions)
// BEHAVIOUR
//  Reset: state=FREE, issued=0, outstanding=0, io_err=0, all valids 0, fthInst_addr=0.
//   io_alloc_ready=0 while reset is high; otherwise io_alloc_ready = (state==FREE).
//  States: FREE=0, FSTTASK=1, NXTTASK=2, WAIT=3, DONE=4. Codes 5-7 unreachable -> FREE next cycle.
//  Outputs are decoded from registered state/counters. No comb path from inputs to valids.
//  FREE: on alloc_valid&&ready, latch base=addr, last=len; issued=0; clear io_err -> FSTTASK.
//  FSTTASK: fthInst_valid=1, addr=base. On ready: issued=1, outstanding+1.
//   If last==0 -> WAIT, else -> NXTTASK. Holds valid/addr stable until ready.
//  NXTTASK: fthInst_valid = (outstanding<MAX_OUT); addr = base + issued*BEAT_BYTES.
//   Address is truncated to ADDR_W and wraps.
//   On handshake: issued+1, outstanding+1. If issued==last -> WAIT.
//  WAIT: when outstanding==0 -> DONE (response in the same cycle counts).
//  DONE: io_done_valid=1 until io_done_ready -> FREE (realloc possible the cycle after).
//  Outstanding counter (width clog2(MAX_OUT+1)):
//   +1 on fthInst handshake, -1 on fthResp_valid; both in the same cycle -> unchanged.
//   Resp with outstanding==0 and no same-cycle issue: ignored, counter stays 0, io_err<=1.
//  io_flush: highest priority, any state. Next cycle: state=FREE, issued=0, outstanding=0.
//   No done pulse. An alloc handshake in the flush cycle is suppressed
//   (io_alloc_ready=0 while io_flush=1). io_err is retained.
//  Latency: alloc handshake at cycle N -> fthInst_valid=1 at N+1 (assertion contract).
//   Back-to-back beats, one per cycle, when ready=1 and outstanding below MAX_OUT.
//  Asynchronous reset mid-task: everything returns to reset values immediately.
// TESTING
//  1. alloc addr=0x1000 len=0, fthInst_ready=1 -> cycle+1 valid addr 0x1000, state 1;
//     resp 2 cycles later -> WAIT->DONE, done_valid=1.
//  2. alloc addr=0x2000 len=3, ready=1, no resps, MAX_OUT=4 -> addrs 0x2000,0x2008,0x2010,
//     0x2018 on consecutive cycles; then WAIT until 4 resps.
//  3. len=7, no resps -> exactly 4 issued, then valid=0 in NXTTASK. One resp -> exactly 1
//     more beat issued. Issue and resp in the same cycle leave outstanding unchanged.
//  4. resp with outstanding=0 in FREE -> io_err=1 sticky; next alloc clears it.
//  5. flush in NXTTASK with 2 outstanding -> FREE next cycle, outstanding=0, no done_valid;
//     alloc in the flush cycle is not accepted.
//  6. assert reset mid-NXTTASK -> stateReg_value=0 and all valids 0 immediately.
//     Random alloc/ready/resp: the state_transfer check FREE&&alloc -> fthInst_valid never fires.

Source files
------------

// File: rtl/fetch_task_fsm.sv
// fetch_task_fsm: single-slot fetch-task controller issuing per-beat fetches and tracking outstanding responses
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   io_alloc_*                   task allocation (addr = base, len = beats-1)
//   io_fthInst_*                 one fetch instruction per beat, addr = base + beat*BEAT_BYTES
//   io_fthResp_valid             one fetch response returned (always accepted)
//   io_flush                     abort current task, back to FREE next cycle
//   io_done_*                    task completion handshake
//   io_err                       sticky: response arrived with nothing outstanding
//   stateReg_value               state encoding exported for assertion checking
module fetch_task_fsm #(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 4,
  parameter int BEAT_BYTES = 8,
  parameter int MAX_OUT    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_alloc_valid,
  output logic              io_alloc_ready,
  input  logic [ADDR_W-1:0] io_alloc_addr,
  input  logic [LEN_W-1:0]  io_alloc_len,
  output logic              io_fthInst_valid,
  input  logic              io_fthInst_ready,
  output logic [ADDR_W-1:0] io_fthInst_addr,
  input  logic              io_fthResp_valid,
  input  logic              io_flush,
  output logic              io_done_valid,
  input  logic              io_done_ready,
  output logic              io_err,
  output logic [2:0]        stateReg_value
);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int IW = LEN_W + 1;
  localparam logic [2:0] FREE = 3'd0, FSTTASK = 3'd1, NXTTASK = 3'd2, WAIT = 3'd3, DONE = 3'd4;
  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  last;
  logic [IW-1:0]     issued;
  logic [OW-1:0]     outstanding, out_nxt;
  logic              err, alloc_hs, fth_hs, stray_resp;
  assign alloc_hs   = io_alloc_valid && io_alloc_ready;
  assign fth_hs     = io_fthInst_valid && io_fthInst_ready;
  // a response with nothing in flight and no same-cycle issue is dropped and flagged
  assign stray_resp = io_fthResp_valid && !fth_hs && outstanding == '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= FREE;
    else       state <= state_nxt;
  always_comb begin
    out_nxt   = fth_hs && !io_fthResp_valid ? outstanding + OW'(1) :
                io_fthResp_valid && !fth_hs && outstanding != '0 ? outstanding - OW'(1) : outstanding;
    state_nxt = io_flush           ? FREE :
                state == FREE      ? (alloc_hs ? FSTTASK : FREE) :
                state == FSTTASK   ? (fth_hs ? (last == '0 ? WAIT : NXTTASK) : FSTTASK) :
                state == NXTTASK   ? (fth_hs && issued == {1'b0, last} ? WAIT : NXTTASK) :
                state == WAIT      ? (out_nxt == '0 ? DONE : WAIT) :
                state == DONE      ? (io_done_ready ? FREE : DONE) : FREE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      base        <= '0;
      last        <= '0;
      issued      <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      outstanding <= io_flush ? '0 : out_nxt;
      issued      <= io_flush || alloc_hs ? '0 : fth_hs ? issued + IW'(1) : issued;
      err         <= stray_resp ? 1'b1 : alloc_hs ? 1'b0 : err;
      if (alloc_hs) begin
        base <= io_alloc_addr;
        last <= io_alloc_len;
      end
    end
  always_comb begin
    io_alloc_ready   = !reset && !io_flush && state == FREE;
    io_fthInst_valid = state == FSTTASK || (state == NXTTASK && outstanding < OW'(MAX_OUT));
    io_fthInst_addr  = base + ADDR_W'(issued) * ADDR_W'(BEAT_BYTES);
    io_done_valid    = state == DONE;
    io_err           = err;
    stateReg_value   = state;
  end
endmodule

// File: tb/tb_fetch_task_fsm.sv
// tb_fetch_task_fsm: directed and random self-checking bench for fetch_task_fsm
module tb_fetch_task_fsm;
  logic        clock = 1'b0, reset = 1'b1;
  logic        io_alloc_valid = 1'b0, io_alloc_ready;
  logic [31:0] io_alloc_addr = '0;
  logic [3:0]  io_alloc_len = '0;
  logic        io_fthInst_valid, io_fthInst_ready = 1'b0;
  logic [31:0] io_fthInst_addr;
  logic        io_fthResp_valid = 1'b0, io_flush = 1'b0;
  logic        io_done_valid, io_done_ready = 1'b0, io_err;
  logic [2:0]  stateReg_value;
  int checks = 0, failures = 0;
  fetch_task_fsm dut (
    .clock(clock), .reset(reset),
    .io_alloc_valid(io_alloc_valid), .io_alloc_ready(io_alloc_ready),
    .io_alloc_addr(io_alloc_addr), .io_alloc_len(io_alloc_len),
    .io_fthInst_valid(io_fthInst_valid), .io_fthInst_ready(io_fthInst_ready),
    .io_fthInst_addr(io_fthInst_addr), .io_fthResp_valid(io_fthResp_valid),
    .io_flush(io_flush), .io_done_valid(io_done_valid), .io_done_ready(io_done_ready),
    .io_err(io_err), .stateReg_value(stateReg_value)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic alloc(input logic [31:0] a, input logic [3:0] l);
    io_alloc_valid = 1'b1;
    io_alloc_addr  = a;
    io_alloc_len   = l;
    cyc();
    io_alloc_valid = 1'b0;
  endtask
  task automatic finish_done();
    io_done_ready = 1'b1;
    cyc();
    io_done_ready = 1'b0;
  endtask
  initial begin
    logic hs, fl;
    cyc(2);
    check("rst_ready", io_alloc_ready, 0);
    check("rst_state", stateReg_value, 0);
    check("rst_fvalid", io_fthInst_valid, 0);
    check("rst_done", io_done_valid, 0);
    check("rst_addr", io_fthInst_addr, 0);
    check("rst_err", io_err, 0);
    reset = 1'b0;
    #1 check("rst_rel_ready", io_alloc_ready, 1);
    io_fthInst_ready = 1'b1;
    alloc(32'h1000, 4'd0);
    check("t1_state", stateReg_value, 1);
    check("t1_valid", io_fthInst_valid, 1);
    check("t1_addr", io_fthInst_addr, 32'h1000);
    check("t1_busy", io_alloc_ready, 0);
    cyc();
    check("t1_wait", stateReg_value, 3);
    check("t1_valid_off", io_fthInst_valid, 0);
    io_fthResp_valid = 1'b1;
    cyc();
    io_fthResp_valid = 1'b0;
    check("t1_done_st", stateReg_value, 4);
    check("t1_done", io_done_valid, 1);
    cyc();
    check("t1_done_hold", stateReg_value, 4);
    finish_done();
    check("t1_free", stateReg_value, 0);
    check("t1_done_off", io_done_valid, 0);
    check("t1_ready", io_alloc_ready, 1);
    alloc(32'h2000, 4'd3);
    for (int i = 0; i < 4; i++) begin
      check("t2_valid", io_fthInst_valid, 1);
      check("t2_addr", io_fthInst_addr, 32'h2000 + 32'(i) * 8);
      cyc();
    end
    check("t2_wait", stateReg_value, 3);
    check("t2_valid_off", io_fthInst_valid, 0);
    io_fthResp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t2_still_wait", stateReg_value, 3);
    end
    cyc();
    io_fthResp_valid = 1'b0;
    check("t2_done", stateReg_value, 4);
    finish_done();
    io_fthResp_valid = 1'b1;
    cyc();
    io_fthResp_valid = 1'b0;
    check("t4_err_set", io_err, 1);
    cyc();
    check("t4_err_sticky", io_err, 1);
    io_flush = 1'b1;
    cyc();
    io_flush = 1'b0;
    check("t4_err_flush", io_err, 1);
    alloc(32'h3000, 4'd7);
    check("t4_err_clr", io_err, 0);
    check("t3_fst", stateReg_value, 1);
    cyc(4);
    check("t3_nxt", stateReg_value, 2);
    check("t3_full", io_fthInst_valid, 0);
    check("t3_addr4", io_fthInst_addr, 32'h3020);
    cyc();
    check("t3_full_hold", io_fthInst_valid, 0);
    io_fthResp_valid = 1'b1;
    cyc();
    io_fthResp_valid = 1'b0;
    check("t3_resume", io_fthInst_valid, 1);
    check("t3_resume_addr", io_fthInst_addr, 32'h3020);
    cyc();
    check("t3_one_more", io_fthInst_valid, 0);
    check("t3_addr5", io_fthInst_addr, 32'h3028);
    io_fthResp_valid = 1'b1;
    cyc();
    check("t3_pre_same", io_fthInst_valid, 1);
    cyc();
    io_fthResp_valid = 1'b0;
    check("t3_same_valid", io_fthInst_valid, 1);
    check("t3_same_addr", io_fthInst_addr, 32'h3030);
    cyc();
    check("t3_same_cycle", io_fthInst_valid, 0);
    check("t3_addr7", io_fthInst_addr, 32'h3038);
    check("t3_state", stateReg_value, 2);
    io_flush = 1'b1;
    cyc();
    io_flush = 1'b0;
    alloc(32'h4000, 4'd7);
    cyc(2);
    io_fthInst_ready = 1'b0;
    check("t5_nxt", stateReg_value, 2);
    check("t5_addr", io_fthInst_addr, 32'h4010);
    io_flush = 1'b1;
    io_alloc_valid = 1'b1;
    io_alloc_addr = 32'h5000;
    io_alloc_len = 4'd0;
    cyc();
    check("t5_free", stateReg_value, 0);
    check("t5_no_done", io_done_valid, 0);
    check("t5_valid_off", io_fthInst_valid, 0);
    check("t5_flush_rdy", io_alloc_ready, 0);
    cyc();
    check("t5_no_alloc", stateReg_value, 0);
    io_flush = 1'b0;
    #1 check("t5_rdy_back", io_alloc_ready, 1);
    io_fthInst_ready = 1'b1;
    cyc();
    io_alloc_valid = 1'b0;
    check("t5_alloc", stateReg_value, 1);
    check("t5_alloc_addr", io_fthInst_addr, 32'h5000);
    cyc();
    io_fthResp_valid = 1'b1;
    cyc();
    io_fthResp_valid = 1'b0;
    check("t5_out_cleared", stateReg_value, 4);
    check("t5_err", io_err, 0);
    finish_done();
    alloc(32'h6000, 4'd7);
    cyc(2);
    check("t6_nxt", stateReg_value, 2);
    #2 reset = 1'b1;
    #1;
    check("t6_state", stateReg_value, 0);
    check("t6_fvalid", io_fthInst_valid, 0);
    check("t6_done", io_done_valid, 0);
    check("t6_ready", io_alloc_ready, 0);
    check("t6_addr", io_fthInst_addr, 0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      io_alloc_valid   = 1'($urandom_range(0, 1));
      io_alloc_addr    = $urandom;
      io_alloc_len     = 4'($urandom_range(0, 15));
      io_fthInst_ready = 1'($urandom_range(0, 1));
      io_fthResp_valid = $urandom_range(0, 3) == 0;
      io_done_ready    = 1'($urandom_range(0, 1));
      io_flush         = $urandom_range(0, 31) == 0;
      #1;
      hs = io_alloc_valid && io_alloc_ready && stateReg_value == 3'd0;
      fl = io_flush;
      @(posedge clock);
      #1;
      if (hs) check("rand_latency", io_fthInst_valid, 1);
      if (fl) check("rand_flush", stateReg_value, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
